ptr_local_inj_arb: RTL and testbench

Local-injection arbiter for the pointer-ring router. It shares one router local write port (l2rWr/l2rDat/destCnt) among REQ_NUM local requesters using round-robin, packet-locked arbitration. A one-entry output register decouples router back-pressure. It sits between a node's local masters and the router's local interface, on the l2r direction only.

---
 rtl/ptr_local_inj_arb.sv | 130 +++++++++++++
 tb/tb_ptr_local_inj_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ptr_local_inj_arb.sv
// rtl/ptr_local_inj_arb.sv - round-robin, packet-locked arbiter sharing one router local write port
// Single-entry output register; a packet owner holds the port until its last beat.
module ptr_local_inj_arb #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int NODE_NUM   = 128,
    localparam int DEST_W    = $clog2(NODE_NUM)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           arbEn_i,
    input  logic [REQ_NUM-1:0]             reqVld_i,
    input  logic [REQ_NUM-1:0]             reqLast_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]  reqDat_i,
    input  logic [REQ_NUM*DEST_W-1:0]      reqDest_i,
    output logic [REQ_NUM-1:0]             reqRdy_o,
    input  logic                           l2rRdy_i,
    output logic                           l2rWr_o,
    output logic [DATA_WIDTH-1:0]          l2rDat_o,
    output logic [DEST_W-1:0]              destCnt_o,
    output logic                           busy_o
);
    localparam int PTR_W = $clog2(REQ_NUM);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic                   o_vld_q, o_vld_d;
    logic [DATA_WIDTH-1:0]  o_dat_q, o_dat_d;
    logic [DEST_W-1:0]      o_dest_q, o_dest_d;

    logic [REQ_NUM-1:0]     cand;
    logic                   win_vld;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W:0]         scan_idx;
    logic [PTR_W-1:0]       sel;
    logic [REQ_NUM-1:0]     rdy;
    logic                   load_en;
    logic                   drain;
    logic                   accept;

    function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(REQ_NUM - 1)) ? '0 : v + 1'b1;
    endfunction

    assign cand    = arbEn_i ? reqVld_i : '0;
    assign load_en = !o_vld_q || l2rRdy_i;
    assign drain   = o_vld_q && l2rRdy_i;

    // Rotating priority scan starting at ptr; index kept one bit wider so the wrap is a subtract.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(REQ_NUM)) begin
                scan_idx = scan_idx - (PTR_W+1)'(REQ_NUM);
            end
            if (!win_vld && cand[scan_idx[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        o_vld_d  = o_vld_q;
        o_dat_d  = o_dat_q;
        o_dest_d = o_dest_q;
        rdy      = '0;
        sel      = (state_q == LOCK) ? owner_q : win_idx;

        if (!rst_i) begin
            if (state_q == LOCK) begin
                rdy[owner_q] = load_en;
            end else if (win_vld) begin
                rdy[win_idx] = load_en;
            end
        end
        accept = |(reqVld_i & rdy);

        if (accept) begin
            o_vld_d = 1'b1;
            o_dat_d = reqDat_i[sel*DATA_WIDTH +: DATA_WIDTH];
            // Destination is captured from the head beat only.
            if (state_q == IDLE) begin
                o_dest_d = reqDest_i[win_idx*DEST_W +: DEST_W];
                owner_d  = win_idx;
            end
            if (reqLast_i[sel]) begin
                state_d = IDLE;
                ptr_d   = inc_mod(sel);
            end else begin
                state_d = LOCK;
            end
        end else if (drain) begin
            o_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            o_vld_q  <= 1'b0;
            o_dat_q  <= '0;
            o_dest_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            o_vld_q  <= o_vld_d;
            o_dat_q  <= o_dat_d;
            o_dest_q <= o_dest_d;
        end
    end

    assign reqRdy_o  = rdy;
    assign l2rWr_o   = o_vld_q;
    assign l2rDat_o  = o_dat_q;
    assign destCnt_o = o_dest_q;
    assign busy_o    = (state_q == LOCK) || o_vld_q;
endmodule

// File: tb/tb_ptr_local_inj_arb.sv
// tb/tb_ptr_local_inj_arb.sv - directed self-checking bench for ptr_local_inj_arb
module tb_ptr_local_inj_arb;
    localparam int RN  = 4;
    localparam int DW  = 128;
    localparam int NN  = 128;
    localparam int DSW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              arb_en;
    logic [RN-1:0]     vld;
    logic [RN-1:0]     last;
    logic [RN*DW-1:0]  dat_bus;
    logic [RN*DSW-1:0] dst_bus;
    logic [RN-1:0]     rdy;
    logic              l2r_rdy;
    logic              wr;
    logic [DW-1:0]     l2r_dat;
    logic [DSW-1:0]    dest_cnt;
    logic              busy;

    logic [DW-1:0]     dat [RN];
    logic [DSW-1:0]    dst [RN];

    int checks = 0;
    int errors = 0;

    ptr_local_inj_arb #(.REQ_NUM(RN), .DATA_WIDTH(DW), .NODE_NUM(NN)) dut (
        .clk_i(clk), .rst_i(rst), .arbEn_i(arb_en),
        .reqVld_i(vld), .reqLast_i(last), .reqDat_i(dat_bus), .reqDest_i(dst_bus),
        .reqRdy_o(rdy), .l2rRdy_i(l2r_rdy), .l2rWr_o(wr), .l2rDat_o(l2r_dat),
        .destCnt_o(dest_cnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        dat_bus = '0;
        dst_bus = '0;
        for (int i = 0; i < RN; i++) begin
            dat_bus[i*DW +: DW]   = dat[i];
            dst_bus[i*DSW +: DSW] = dst[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; arb_en = 1'b1; l2r_rdy = 1'b1; vld = 4'hF; last = 4'hF;
        for (int i = 0; i < RN; i++) begin
            dat[i] = DW'(16'hA000 + i);
            dst[i] = DSW'(5 + 9 * i);
        end
        tick; tick;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b exp 0", wr); end
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (dest_cnt !== 7'd0 || l2r_dat !== '0) begin errors++; $display("FAIL reset_out got dest %h dat %h exp 0", dest_cnt, l2r_dat); end
        rst = 1'b0;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL release_rdy got %b exp 0001", rdy); end
        tick;
        checks++; if (wr !== 1'b1 || l2r_dat !== dat[0] || dest_cnt !== dst[0]) begin
            errors++; $display("FAIL first_beat got wr %0b dat %h dest %h exp 1 %h %h", wr, l2r_dat, dest_cnt, dat[0], dst[0]);
        end
    endtask

    task automatic test_round_robin;
        int g;
        for (int k = 1; k <= 7; k++) begin
            g = k % RN;
            checks++; if (rdy !== 4'(1 << g)) begin errors++; $display("FAIL rr_rdy step %0d got %b exp %b", k, rdy, 4'(1 << g)); end
            tick;
            checks++; if (wr !== 1'b1 || l2r_dat !== dat[g] || dest_cnt !== dst[g]) begin
                errors++; $display("FAIL rr_out step %0d got wr %0b dat %h dest %h exp 1 %h %h", k, wr, l2r_dat, dest_cnt, dat[g], dst[g]);
            end
        end
        vld = 4'b0000;
        tick;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rr_drain got %0b exp 0", wr); end
    endtask

    task automatic test_packet_lock;
        vld = 4'b0001; last = 4'b0001;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL lock_pre_rdy got %b exp 0001", rdy); end
        tick;
        vld = 4'b0111; last = 4'b0101; dst[1] = 7'h2A;
        for (int b = 0; b < 3; b++) begin
            dat[1] = DW'(16'hB100 + b);
            if (b > 0) dst[1] = 7'h11;
            if (b == 2) last[1] = 1'b1;
            #1;
            checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL lock_rdy beat %0d got %b exp 0010", b, rdy); end
            tick;
            checks++; if (l2r_dat !== DW'(16'hB100 + b) || dest_cnt !== 7'h2A) begin
                errors++; $display("FAIL lock_out beat %0d got dat %h dest %h exp %h 2a", b, l2r_dat, dest_cnt, DW'(16'hB100 + b));
            end
        end
        #1;
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL lock_next_rdy got %b exp 0100", rdy); end
        tick;
        checks++; if (l2r_dat !== dat[2] || dest_cnt !== dst[2]) begin errors++; $display("FAIL lock_next_out got %h %h exp %h %h", l2r_dat, dest_cnt, dat[2], dst[2]); end
        vld = 4'b0000;
        tick;
    endtask

    task automatic test_back_pressure;
        vld = 4'b1000; last = 4'b0000; dat[3] = DW'(16'hC001);
        #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL bp_head_rdy got %b exp 1000", rdy); end
        tick;
        dat[3] = DW'(16'hC002); l2r_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL bp_stall_rdy cyc %0d got %b exp 0000", c, rdy); end
            tick;
            checks++; if (wr !== 1'b1 || l2r_dat !== DW'(16'hC001) || busy !== 1'b1) begin
                errors++; $display("FAIL bp_stall_out cyc %0d got wr %0b dat %h busy %0b exp 1 c001 1", c, wr, l2r_dat, busy);
            end
        end
        l2r_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL bp_resume_rdy got %b exp 1000", rdy); end
        tick;
        checks++; if (wr !== 1'b1 || l2r_dat !== DW'(16'hC002)) begin errors++; $display("FAIL bp_beat2 got wr %0b dat %h exp 1 c002", wr, l2r_dat); end
        dat[3] = DW'(16'hC003); last = 4'b1000;
        #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL bp_beat3_rdy got %b exp 1000", rdy); end
        tick;
        checks++; if (l2r_dat !== DW'(16'hC003)) begin errors++; $display("FAIL bp_beat3 got %h exp c003", l2r_dat); end
        vld = 4'b0000;
        tick;
        checks++; if (wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end got wr %0b busy %0b exp 0 0", wr, busy); end
    endtask

    task automatic test_arb_en;
        vld = 4'b1000; last = 4'b0000;
        for (int b = 1; b <= 4; b++) begin
            dat[3] = DW'(16'hE000 + b);
            if (b == 2) arb_en = 1'b0;
            if (b == 4) last = 4'b1000;
            #1;
            checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL en_rdy beat %0d got %b exp 1000", b, rdy); end
            tick;
            checks++; if (l2r_dat !== DW'(16'hE000 + b)) begin errors++; $display("FAIL en_out beat %0d got %h exp %h", b, l2r_dat, DW'(16'hE000 + b)); end
        end
        vld = 4'b1111; last = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL en_off_rdy cyc %0d got %b exp 0000", c, rdy); end
            tick;
        end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL en_off_drain got %0b exp 0", wr); end
        arb_en = 1'b1;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL en_wrap_rdy got %b exp 0001", rdy); end
        tick;
        checks++; if (l2r_dat !== dat[0]) begin errors++; $display("FAIL en_wrap_out got %h exp %h", l2r_dat, dat[0]); end
        vld = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid;
        vld = 4'b0100; last = 4'b0000; dat[2] = DW'(16'hF001);
        #1;
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL rm_head_rdy got %b exp 0100", rdy); end
        tick;
        dat[2] = DW'(16'hF002);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (wr !== 1'b0 || rdy !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_async got wr %0b rdy %b busy %0b exp 0 0000 0", wr, rdy, busy);
        end
        tick;
        rst = 1'b0; vld = 4'b0101; last = 4'b0101;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL rm_release_rdy got %b exp 0001", rdy); end
        tick;
        checks++; if (wr !== 1'b1 || l2r_dat !== dat[0] || dest_cnt !== dst[0]) begin
            errors++; $display("FAIL rm_release_out got wr %0b dat %h dest %h exp 1 %h %h", wr, l2r_dat, dest_cnt, dat[0], dst[0]);
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_packet_lock;
        test_back_pressure;
        test_arb_en;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
